parallel_dlatch_arbiter: RTL
============================

PARALLEL_DLATCH_ARBITER -- requirements
Module: parallel_dlatch_arbiter

Interface
REQ-001 Parameters SHALL be: WAY, default 3, number of latch ways and requesters; WIRE, default 8, bits per way.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  WAY  per-requester write request, level; bit i belongs to way i.
REQ-005 clr  input  WAY  per-way clear request, level.
REQ-006 wdata  input  WAY*WIRE  write data; slice [i*WIRE +: WIRE] belongs to requester i.
REQ-007 grant  output  WAY  one-hot owner of the write in progress; all zero when no write is in progress.
REQ-008 done  output  1  one-cycle pulse marking write completion for the way in grant.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 latch_en  output  WAY  per-way latch enable; drives the clk vector of the latch bank.
REQ-011 latch_rst  output  WAY  per-way latch reset; drives the rst vector of the latch bank.
REQ-012 latch_d  output  WAY*WIRE  latch bank D input; the captured word SHALL be replicated into every way slice.

Function
REQ-013 All outputs SHALL be registered; FSM states SHALL be IDLE, CLEAR, SETUP, OPEN and HOLD.
REQ-014 IDLE with clr != 0: next state CLEAR, latch_rst <= clr; clr SHALL take priority over req in the same cycle.
REQ-015 CLEAR: one cycle, then IDLE with latch_rst <= 0; any req pending during CLEAR SHALL be arbitrated in the following IDLE cycle.
REQ-016 IDLE with clr == 0 and req != 0: round-robin winner w chosen, search starting at pointer ptr upward modulo WAY; next state SETUP; grant <= onehot(w); latch_d <= wdata slice w replicated WAY times.
REQ-017 SETUP: latch_en = 0, latch_d stable; next state OPEN.
REQ-018 OPEN: latch_en = grant for exactly one cycle; latch_d unchanged; next state HOLD.
REQ-019 HOLD: latch_en = 0, latch_d unchanged, done = 1, grant still valid; next state IDLE with grant <= 0; ptr <= (w+1) mod WAY.
REQ-020 Latency SHALL be: req sampled in IDLE at edge N; grant visible N+1; latch_en high N+2; done high N+3; IDLE again N+4; a back-to-back write therefore SHALL take 4 cycles.
REQ-021 req and clr SHALL be ignored outside IDLE, and wdata SHALL be sampled only at the IDLE->SETUP edge.
REQ-022 A requester holding req after done SHALL be treated as a new request; round-robin SHALL then serve other pending ways first.
REQ-023 At most one latch_en bit SHALL be high at any time, and latch_en and latch_rst SHALL never be high on the same way in the same cycle.
REQ-024 ptr wrap-around: after serving way WAY-1, ptr SHALL be 0.

Reset
REQ-025 An edge with rst=1 SHALL force state IDLE, ptr 0, grant 0, done 0, busy 0, latch_en 0, latch_d 0, and latch_rst all ones (clears the whole bank).
REQ-026 The first edge with rst=0 SHALL return latch_rst to 0, unless REQ-014 applies.
REQ-027 rst asserted in SETUP, OPEN or HOLD SHALL abort the write at that edge with no done pulse, and latch_en SHALL be 0 from that edge.

Verification (WAY=3, WIRE=8)
REQ-028 rst=1 for 2 cycles, then 0 -> latch_rst=3'b111 during reset, 3'b000 after; all other outputs 0.
REQ-029 req=3'b010, wdata slice1=8'hA5 -> grant=3'b010 at N+1, latch_d=24'hA5A5A5, latch_en=3'b010 at N+2 only, done at N+3.
REQ-030 req=3'b111 held throughout -> grant order 001, 010, 100, 001; one done every 4 cycles; latch_en never multi-hot.
REQ-031 clr=3'b101 and req=3'b001 in the same IDLE cycle -> latch_rst=3'b101 for one cycle first, then the write to way0 starts the next cycle.
REQ-032 rst pulsed during OPEN of a write to way2 -> latch_en=0 at the next edge, no done, latch_rst=3'b111, ptr=0.
REQ-033 req=3'b100 served, then req=3'b101 -> way0 wins (ptr wrapped to 0), then way2.

Source files
------------

// File: rtl/parallel_dlatch_arbiter.sv
// Round-robin arbiter that drives a bank of WAY transparent latches.
// Each write is a fixed four-cycle sequence: SETUP (data settles),
// OPEN (one-cycle enable), HOLD (data held, done pulse) and back to IDLE.
// Per-way clears take one CLEAR cycle and win over writes.
module parallel_dlatch_arbiter #(
  parameter int WAY  = 3,
  parameter int WIRE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WAY-1:0]      req,
  input  logic [WAY-1:0]      clr,
  input  logic [WAY*WIRE-1:0] wdata,
  output logic [WAY-1:0]      grant,
  output logic                done,
  output logic                busy,
  output logic [WAY-1:0]      latch_en,
  output logic [WAY-1:0]      latch_rst,
  output logic [WAY*WIRE-1:0] latch_d
);

  localparam int               PTR_W = (WAY > 1) ? $clog2(WAY) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(WAY - 1);
  localparam logic [PTR_W:0]   WAY_W = (PTR_W + 1)'(WAY);
  localparam logic [WAY-1:0]   ONE   = WAY'(1);

  typedef enum logic [2:0] {IDLE, CLEAR, SETUP, OPEN, HOLD} state_t;

  state_t                state_reg, state_next;
  logic [PTR_W-1:0]      ptr_reg, ptr_next;
  logic [PTR_W-1:0]      w_reg, w_next;
  logic [WAY-1:0]        grant_reg, grant_next;
  logic                  done_reg, done_next;
  logic                  busy_reg, busy_next;
  logic [WAY-1:0]        latch_en_reg, latch_en_next;
  logic [WAY-1:0]        latch_rst_reg, latch_rst_next;
  logic [WAY*WIRE-1:0]   latch_d_reg, latch_d_next;

  // Round-robin search: rotate the request vector so the pointer way sits
  // at bit 0, pick the lowest set bit, then rotate the offset back.
  logic [2*WAY-1:0]           req_dbl;
  logic [WAY-1:0]             req_rot;
  logic [WAY-1:0]             first_hot;
  logic [WAY:0][PTR_W-1:0]    off_acc;
  logic [PTR_W:0]             win_sum;
  logic [PTR_W-1:0]           win_idx;
  logic [WIRE-1:0]            sel_word;
  logic [WAY*WIRE-1:0]        rep_word;

  assign req_dbl    = {req, req};
  assign req_rot    = req_dbl[ptr_reg +: WAY];
  assign off_acc[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < WAY; gi++) begin : g_pick
      if (gi == 0) begin : g_first
        assign first_hot[gi] = req_rot[gi];
      end else begin : g_rest
        assign first_hot[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
      end
      assign off_acc[gi+1] = off_acc[gi] | (first_hot[gi] ? PTR_W'(gi) : '0);
    end
  endgenerate

  assign win_sum = {1'b0, ptr_reg} + {1'b0, off_acc[WAY]};
  assign win_idx = (win_sum >= WAY_W) ? PTR_W'(win_sum - WAY_W) : win_sum[PTR_W-1:0];
  assign sel_word = wdata[win_idx*WIRE +: WIRE];

  // The captured word is copied into every way slice of the latch bank.
  generate
    for (gi = 0; gi < WAY; gi++) begin : g_rep
      assign rep_word[gi*WIRE +: WIRE] = sel_word;
    end
  endgenerate

  // Next-state and next-output logic; registered outputs are held by default.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    w_next         = w_reg;
    grant_next     = grant_reg;
    done_next      = 1'b0;
    latch_en_next  = '0;
    latch_rst_next = '0;
    latch_d_next   = latch_d_reg;
    case (state_reg)
      IDLE: begin
        // clr is zero when no clear is requested, so this also drops the
        // power-on bank reset on the first edge out of reset.
        latch_rst_next = clr;
        if (clr != '0) begin
          state_next = CLEAR;
        end else if (req != '0) begin
          state_next   = SETUP;
          w_next       = win_idx;
          grant_next   = ONE << win_idx;
          latch_d_next = rep_word;
        end
      end
      CLEAR: begin
        state_next = IDLE;
      end
      SETUP: begin
        state_next    = OPEN;
        latch_en_next = grant_reg;
      end
      OPEN: begin
        state_next = HOLD;
        done_next  = 1'b1;
      end
      HOLD: begin
        state_next = IDLE;
        grant_next = '0;
        ptr_next   = (w_reg == LAST) ? '0 : w_reg + 1'b1;
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and output registers; reset aborts any write and clears the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      w_reg         <= '0;
      grant_reg     <= '0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      latch_en_reg  <= '0;
      latch_rst_reg <= '1;
      latch_d_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      w_reg         <= w_next;
      grant_reg     <= grant_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
      latch_en_reg  <= latch_en_next;
      latch_rst_reg <= latch_rst_next;
      latch_d_reg   <= latch_d_next;
    end
  end

  assign grant     = grant_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;
  assign latch_en  = latch_en_reg;
  assign latch_rst = latch_rst_reg;
  assign latch_d   = latch_d_reg;

endmodule
